// File: rtl/pwr_en_seq.sv
// Power-enable sequencer: steps a masked lane pattern (static, ramp-up,
// walking-one, ramp-down) across NUM_MODULES enables, D cycles per step.
// Ports: clk100m, rstn (sync, active-low), start, abort, mode[1:0],
//   repeat_en, mask_in[N], dwell_cycles[DWELL_W] -> pwr_en_out[N], busy,
//   done (pulse per pass), step_idx[5:0].
module pwr_en_seq #(
  parameter int NUM_MODULES = 32,
  parameter int DWELL_W     = 32
) (
  input  logic                   clk100m,
  input  logic                   rstn,
  input  logic                   start,
  input  logic                   abort,
  input  logic [1:0]             mode,
  input  logic                   repeat_en,
  input  logic [NUM_MODULES-1:0] mask_in,
  input  logic [DWELL_W-1:0]     dwell_cycles,
  output logic [NUM_MODULES-1:0] pwr_en_out,
  output logic                   busy,
  output logic                   done,
  output logic [5:0]             step_idx
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [6:0] NM7 = 7'(NUM_MODULES);
  localparam logic [5:0] NM6 = 6'(NUM_MODULES);

  state_t                 state;
  logic [1:0]             mode_q;
  logic                   rep_q;
  logic [NUM_MODULES-1:0] mask_q;
  logic [DWELL_W-1:0]     dlim_q;
  logic [DWELL_W-1:0]     dcnt;
  logic [5:0]             last_q;
  logic [5:0]             step_q;
  logic [5:0]             step_nx;
  logic [DWELL_W-1:0]     dlim_in;

  function automatic logic [NUM_MODULES-1:0] pat(
    input logic [1:0] m,
    input logic [5:0] k
  );
    logic [NUM_MODULES-1:0] p;
    logic [6:0]             kk;
    logic [6:0]             ii;
    kk = {1'b0, k};
    p  = '0;
    for (int i = 0; i < NUM_MODULES; i++) begin
      ii = 7'(i);
      unique case (m)
        2'd0:    p[i] = 1'b1;
        2'd1:    p[i] = (ii < kk);
        2'd2:    p[i] = (ii == kk);
        default: p[i] = (ii < (NM7 - kk));
      endcase
    end
    return p;
  endfunction

  // Index of the final step of a pass (S-1).
  function automatic logic [5:0] last_of(input logic [1:0] m);
    logic [5:0] r;
    unique case (m)
      2'd0:    r = 6'd0;
      2'd2:    r = NM6 - 6'd1;
      default: r = NM6;
    endcase
    return r;
  endfunction

  // Store D-1 so an all-ones dwell never needs a wider counter.
  assign dlim_in  = (dwell_cycles == '0) ? '0
                  : dwell_cycles - DWELL_W'(1);
  assign step_nx  = step_q + 6'd1;
  assign step_idx = step_q;

  always_ff @(posedge clk100m) begin
    if (!rstn) begin
      state      <= IDLE;
      mode_q     <= '0;
      rep_q      <= 1'b0;
      mask_q     <= '0;
      dlim_q     <= '0;
      dcnt       <= '0;
      last_q     <= '0;
      step_q     <= '0;
      pwr_en_out <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            state      <= RUN;
            mode_q     <= mode;
            rep_q      <= repeat_en;
            mask_q     <= mask_in;
            dlim_q     <= dlim_in;
            last_q     <= last_of(mode);
            dcnt       <= '0;
            step_q     <= '0;
            busy       <= 1'b1;
            pwr_en_out <= pat(mode, 6'd0) & mask_in;
          end
        end
        RUN: begin
          if (abort) begin
            state      <= IDLE;
            dcnt       <= '0;
            step_q     <= '0;
            busy       <= 1'b0;
            pwr_en_out <= '0;
          end else if (dcnt != dlim_q) begin
            dcnt <= dcnt + DWELL_W'(1);
          end else begin
            dcnt <= '0;
            if (step_q != last_q) begin
              step_q     <= step_nx;
              pwr_en_out <= pat(mode_q, step_nx) & mask_q;
            end else begin
              done   <= 1'b1;
              step_q <= '0;
              if (rep_q) begin
                pwr_en_out <= pat(mode_q, 6'd0) & mask_q;
              end else begin
                state      <= IDLE;
                busy       <= 1'b0;
                pwr_en_out <= '0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pwr_en_seq.md
PWR_EN_SEQ -- requirements
Module: pwr_en_seq

Interface
REQ-001 Parameter NUM_MODULES, default 32, sets the number of power-enable lanes; legal range 1..32.
REQ-002 Parameter DWELL_W, default 32, sets the width of the dwell counter.
REQ-003 clk100m  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  single-cycle request to begin a sequence.
REQ-006 abort  input  1  terminate any running sequence.
REQ-007 mode  input  2  pattern select: 0 static, 1 ramp-up, 2 walking-one, 3 ramp-down.
REQ-008 repeat_en  input  1  restart the sequence automatically after its last step.
REQ-009 mask_in  input  NUM_MODULES  per-lane qualifier ANDed into every pattern.
REQ-010 dwell_cycles  input  DWELL_W  clock cycles per step; a value of 0 SHALL be treated as 1.
REQ-011 pwr_en_out  output  NUM_MODULES  registered per-lane enables driving the user module array.
REQ-012 busy  output  1  high while a sequence is running.
REQ-013 done  output  1  single-cycle pulse at the end of each completed pass.
REQ-014 step_idx  output  6  index of the current step; 0 when idle.

Function
REQ-015 FSM states SHALL be IDLE and RUN only.
REQ-016 IDLE to RUN SHALL occur when start=1 and abort=0 in IDLE; mode, repeat_en, mask_in and dwell_cycles SHALL be captured in that cycle.
REQ-017 Input changes during RUN SHALL be ignored; start during RUN SHALL be ignored.
REQ-018 Step count S SHALL be: mode 0 -> 1; mode 1 -> NUM_MODULES+1; mode 2 -> NUM_MODULES; mode 3 -> NUM_MODULES+1.
REQ-019 The raw pattern for step k SHALL be:
- mode 0: all ones.
- mode 1: the lowest k bits set.
- mode 2: only bit k set.
- mode 3: the lowest NUM_MODULES-k bits set.
REQ-020 pwr_en_out SHALL equal the raw pattern AND the captured mask during RUN, and SHALL be all zeros in IDLE.
REQ-021 Given start sampled at cycle T and D = max(dwell_cycles,1), step k SHALL be presented on cycles T+1+k*D through T+(k+1)*D inclusive.
REQ-022 busy SHALL be 1 exactly on cycles where the FSM is in RUN, starting at T+1.
REQ-023 With repeat_en=0, at cycle T+S*D+1:
- pwr_en_out=0, busy=0, step_idx=0, done=1.
- FSM returns to IDLE.
REQ-024 With repeat_en=1, at cycle T+S*D+1:
- done=1 and busy stays 1.
- step 0 is presented with no gap cycle.
- Passes continue until abort.
REQ-025 abort=1 in RUN SHALL produce, on the next cycle: pwr_en_out=0, busy=0, step_idx=0, done=0, state IDLE.
REQ-026 abort on the same cycle as a pass end SHALL win: done SHALL NOT pulse.
REQ-027 If abort and start are both 1 in IDLE, abort SHALL win and the FSM SHALL stay in IDLE.
REQ-028 The dwell counter SHALL count to D-1 without overflow for any DWELL_W-bit value, including all ones.
REQ-029 start may be asserted in the same cycle done is high after a non-repeat pass; it SHALL be accepted, and step 0 SHALL follow on the next cycle.

Reset
REQ-030 While rstn=0, on each clock edge: FSM to IDLE, pwr_en_out=0, busy=0, done=0, step_idx=0, dwell counter and captured configuration cleared.
REQ-031 Reset asserted mid-sequence SHALL take effect on the next edge with no done pulse.
REQ-032 After reset release, no sequence SHALL start without a new start pulse.

Verification
REQ-033 Static: mode=0, mask=0x0000_00F0, dwell=3, start at T -> pwr_en_out=0xF0 on T+1..T+3; at T+4: out=0, done=1, busy=0.
REQ-034 Ramp-up: mode=1, mask=0xFFFF_FFFF, dwell=1 -> out steps 0x0, 0x1, 0x3, ... 0xFFFF_FFFF over 33 cycles; done at T+34.
REQ-035 Walking-one under mask: mode=2, mask=0xAAAA_AAAA, dwell=0 -> out alternates 0 and 1<<k for k=0..31; done at T+33.
REQ-036 Abort: mode=3, dwell=10, abort at T+15 -> out=0 and busy=0 at T+16; done never pulses.
REQ-037 Repeat: mode=0, repeat_en=1, dwell=2 -> done pulses at T+3, T+5, T+7; busy stays high; out never drops to 0.
REQ-038 Reset mid-run and start-during-busy: rstn low at T+5 -> all outputs 0 at T+6; start during RUN -> no effect on timing.
